sram_ctrl: RTL
==============

# sram_ctrl

Memory-side controller between the load/store unit's data-memory request path and the board's external 16-bit asynchronous SRAM. It accepts one 32-bit word request at a time and splits it into one or two half-word SRAM phases, honouring byte strobes. It returns a single-cycle response pulse carrying assembled read data. Writes with no strobe bits set complete without touching the SRAM.

## Interface
Parameters:
- SRAM_ADDR_W, 18: SRAM half-word address width.
- WAIT_CYCLES, 1: active cycles per SRAM phase. Must be ≥1; 0 is a compile-time error.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high. Clock port is `i_clk`; reset port is `i_rst`.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_req_vld  in  1  request valid.
- o_req_rdy  out  1  controller idle; request accepted on `i_req_vld & o_req_rdy` at a rising edge.
- i_addr  in  32  byte address; only bits [SRAM_ADDR_W:2] are used.
- i_wren  in  1  1 = write, 0 = read.
- i_wdata  in  32  write data.
- i_strb  in  4  byte strobes for writes; ignored for reads.
- o_rdata  out  32  read data; valid with o_rsp_vld and held until the next response.
- o_rsp_vld  out  1  one-cycle completion pulse, for both reads and writes.
- SRAM_ADDR  out  SRAM_ADDR_W  half-word address.
- SRAM_DQ  inout  16  data bus.
- SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low SRAM controls.

## Operation
- **Request acceptance.** Inputs are sampled only at the accept edge and latched. `i_req_vld` while not ready is ignored.
- **Address map.** `SRAM_ADDR = {i_addr[SRAM_ADDR_W:2], half}`.
  - half 0 carries bytes 1:0 (`wdata[15:0]`).
  - half 1 carries bytes 3:2 (`wdata[31:16]`).
- **Phases needed.**
  - Read: both halves, low then high.
  - Write: low half if `strb[1:0] != 0`; high half if `strb[3:2] != 0`. The low half goes first when both are needed.
  - Write with `strb == 0`: accept goes straight to RESP.
- **States.**
  - IDLE: `o_req_rdy = 1`. On accept, go to SETUP with the first required half, or to RESP for a zero-strobe write.
  - SETUP (1 cycle): CE_N = 0; address valid; OE_N = WE_N = 1; LB_N/UB_N = ~strb pair for writes, 0/0 for reads.
  - ACCESS (WAIT_CYCLES cycles, counter-timed):
    - Read: OE_N = 0. SRAM_DQ is captured into the current half of o_rdata at the edge ending the last ACCESS cycle.
    - Write: WE_N = 0.
    - Exit: if another half is required, set half = 1 and go to SETUP; otherwise go to RESP.
  - RESP (1 cycle): o_rsp_vld = 1; all SRAM controls deasserted; then IDLE.
- **DQ drive.** SRAM_DQ is driven with the selected wdata half only for writes in SETUP and ACCESS; it is high-Z otherwise. All SRAM pins are Moore outputs of registered state.
- **Read-data hold.** o_rdata keeps its previous value across write responses.
- **Reset values.**
  - state = IDLE, so o_req_rdy = 1.
  - o_rsp_vld = 0; o_rdata = 0.
  - SRAM_ADDR = 0; all `*_N` = 1; DQ high-Z.
- **Reset mid-operation.** Aborts immediately and asynchronously. Pins deassert, no response is produced, and the partial write is not replayed.

## Timing
- Accept edge E0.
- Response cycle (o_rsp_vld high) follows edge E0+N, where N is:
  - two halves: N = 2·(1+WAIT_CYCLES), i.e. 4 at default;
  - one half: N = 1+WAIT_CYCLES;
  - zero-strobe write: N = 0, so o_rsp_vld is high in the cycle after E0.
- Next accept is possible at the edge ending the RESP cycle's following IDLE cycle, because o_req_rdy is low during RESP.
- Throughput for back-to-back reads: one per `2·(1+WAIT_CYCLES)+2` cycles.
- WE_N low width is exactly WAIT_CYCLES cycles per phase. Address and DQ are stable one cycle before WE_N falls and through the edge where it rises.

## Structure
- `sram_ctrl_state_e` (IDLE, SETUP, ACCESS, RESP) belongs in `singlecycle_pkg`.
- Single module; no sub-module is warranted.
- DQ tristate is a continuous assign in this module.

## Test plan
- **Full write.** Write, addr 0x10, wdata 0xDEADBEEF, strb 0xF, W=1 → SRAM_ADDR 0x00008 then 0x00009; DQ 0xBEEF then 0xDEAD; WE_N low 1 cycle per phase; o_rsp_vld after E0+4.
- **Read-back.** Read addr 0x10 → OE_N low twice, WE_N never low, o_rdata = 0xDEADBEEF with o_rsp_vld after E0+4.
- **Byte write.** Write addr 0x10, strb 0b0100, wdata 0x00AA0000 → single phase at SRAM_ADDR 0x00009, LB_N = 0, UB_N = 1, DQ 0x00AA; response after E0+2. A subsequent read returns 0xDEAABEEF.
- **Zero-strobe write.** Write strb 0 → CE_N stays 1; o_rsp_vld in the cycle after E0.
- **Slow SRAM.** WAIT_CYCLES=3 read → OE_N low 3 cycles per half; response after E0+8.
- **Reset mid-write.** i_rst asserted during ACCESS of a write → CE_N/WE_N go 1 and DQ goes Z without waiting for a clock; no o_rsp_vld; after release, a new read completes normally.

Source files
------------

// File: rtl/singlecycle_pkg.sv
// ============================================================================
// Module      : singlecycle_pkg
// Description : Shared types for the data-memory SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package singlecycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } sram_ctrl_state_e;

  localparam int unsigned DQ_W = 16;

endpackage

`default_nettype wire

// File: rtl/sram_ctrl.sv
// ============================================================================
// Module      : sram_ctrl
// Description : Splits 32-bit word requests into strobed 16-bit async SRAM phases.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_ctrl
  import singlecycle_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_vld,
  output logic                   o_req_rdy,
  input  logic [31:0]            i_addr,
  input  logic                   i_wren,
  input  logic [31:0]            i_wdata,
  input  logic [3:0]             i_strb,
  output logic [31:0]            o_rdata,
  output logic                   o_rsp_vld,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DQ_W-1:0]        SRAM_DQ,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_UB_N
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES == 0) begin : g_wait_check
      $error("WAIT_CYCLES must be at least 1");
    end
  endgenerate

  sram_ctrl_state_e       state_q, state_d;
  logic                   half_q, half_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wren_q, wren_d;
  logic [3:0]             strb_q, strb_d;
  logic [SRAM_ADDR_W-2:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   w_active;
  logic [DQ_W-1:0]        w_wdata_half;
  logic                   w_unused;

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    wren_d  = wren_q;
    strb_d  = strb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req_vld) begin
          // Reads are held as all-lanes-enabled so the lane and phase logic is shared
          wren_d  = i_wren;
          strb_d  = i_wren ? i_strb : 4'hF;
          addr_d  = i_addr[SRAM_ADDR_W:2];
          wdata_d = i_wdata;
          if (i_wren && (i_strb == 4'h0)) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_SETUP;
            half_d  = i_wren && (i_strb[1:0] == 2'b00);
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (!wren_q) begin
            if (half_q) rdata_d[31:16] = SRAM_DQ;
            else        rdata_d[15:0]  = SRAM_DQ;
          end
          if (!half_q && (strb_q[3:2] != 2'b00)) begin
            half_d  = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      wren_q  <= 1'b0;
      strb_q  <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      wren_q  <= wren_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins decode purely from registered state so reset releases them instantly
  assign w_active     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign w_wdata_half = half_q ? wdata_q[31:16] : wdata_q[15:0];

  assign o_req_rdy = (state_q == ST_IDLE);
  assign o_rsp_vld = (state_q == ST_RESP);
  assign o_rdata   = rdata_q;

  assign SRAM_ADDR = {addr_q, half_q};
  assign SRAM_CE_N = ~w_active;
  assign SRAM_OE_N = ~((state_q == ST_ACCESS) && !wren_q);
  assign SRAM_WE_N = ~((state_q == ST_ACCESS) && wren_q);
  assign SRAM_LB_N = ~(w_active && (half_q ? strb_q[2] : strb_q[0]));
  assign SRAM_UB_N = ~(w_active && (half_q ? strb_q[3] : strb_q[1]));
  assign SRAM_DQ   = (w_active && wren_q) ? w_wdata_half : {DQ_W{1'bz}};

  assign w_unused = &{1'b0, i_addr[31:SRAM_ADDR_W+1], i_addr[1:0]};

endmodule

`default_nettype wire
